// File: rtl/bcd_countdown_timer.sv
`timescale 1ns/1ps
// Two-digit BCD countdown timer with IDLE/RUN/PAUSED/DONE control FSM.
// Ports:
//   clk, reset (async, active-high)
//   load, load_tens[3:0], load_ones[3:0] : load a count, return to IDLE
//   start, tick, pause : control inputs
//   tens[3:0], ones[3:0] : registered BCD count
//   zero : count is 00
//   running : state is RUN
//   expired : one-cycle pulse on entry to DONE
module bcd_countdown_timer #(
    parameter int DEFAULT_TENS = 6,
    parameter int DEFAULT_ONES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       tick,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero,
    output logic       running,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] RST_TENS =
        (DEFAULT_TENS > 9) ? 4'd9 : 4'(DEFAULT_TENS);
    localparam logic [3:0] RST_ONES =
        (DEFAULT_ONES > 9) ? 4'd9 : 4'(DEFAULT_ONES);

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       expired_q, expired_d;

    logic       cnt_zero;
    logic       cnt_one;

    assign cnt_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign cnt_one  = (tens_q == 4'd0) && (ones_q == 4'd1);

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        expired_d = 1'b0;

        if (load) begin
            tens_d  = clamp9(load_tens);
            ones_d  = clamp9(load_ones);
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cnt_zero) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // pause wins over a same-cycle tick
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick && !cnt_zero) begin
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                        if (cnt_one) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tens_q    <= RST_TENS;
            ones_q    <= RST_ONES;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            expired_q <= expired_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign zero    = cnt_zero;
    assign running = (state_q == RUN);
    assign expired = expired_q;

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Parameters
REQ-001 DEFAULT_TENS, 6, tens digit loaded at reset (0-9).
REQ-002 DEFAULT_ONES, 0, ones digit loaded at reset (0-9).

Interface
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  level; copy load_tens/load_ones into the counter.
REQ-006 load_tens  input  4  BCD tens digit to load.
REQ-007 load_ones  input  4  BCD ones digit to load.
REQ-008 start  input  1  level; begin counting from IDLE.
REQ-009 tick  input  1  single-cycle count strobe, one strobe per decrement.
REQ-010 pause  input  1  level; freeze counting while high.
REQ-011 tens  output  4  current tens digit, registered, always 0-9.
REQ-012 ones  output  4  current ones digit, registered, always 0-9.
REQ-013 zero  output  1  high whenever tens==0 and ones==0.
REQ-014 running  output  1  high only in state RUN.
REQ-015 expired  output  1  one-cycle pulse on entry to DONE.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, PAUSED, DONE.
REQ-017 IDLE: start=1 and count!=00 -> RUN; start=1 and count==00 -> DONE with expired pulse; otherwise hold.
REQ-018 RUN: pause=1 -> PAUSED with no decrement, even if tick=1 in the same cycle.
REQ-019 RUN: tick=1 and pause=0 -> decrement the count by one on that edge (zero added latency).
REQ-020 Decrement rule: ones!=0 -> ones-1; ones==0 -> ones=9 and tens-1 (borrow).
REQ-021 RUN: the decrement from 01 to 00 -> DONE on the same edge, with expired=1 for exactly the following cycle.
REQ-022 The count SHALL never wrap below 00 or decrement in IDLE, PAUSED or DONE.
REQ-023 PAUSED: pause=0 -> RUN; ticks in PAUSED are ignored and not queued.
REQ-024 DONE: hold 00 and zero=1; start is ignored; only load or reset exits DONE.
REQ-025 load=1 in any state -> count=loaded digits and state=IDLE on that edge; load has priority over start, tick and pause.
REQ-026 A load digit greater than 9 SHALL be clamped to 9 before storing.
REQ-027 expired SHALL NOT assert on load, reset, or on any transition other than entry to DONE.
REQ-028 start in RUN or PAUSED SHALL be ignored.
REQ-029 zero and running SHALL be decoded from registered state, with no dependence on same-cycle inputs.

Reset
REQ-030 reset=1 SHALL immediately force tens=DEFAULT_TENS, ones=DEFAULT_ONES, state=IDLE, expired=0, running=0, independent of clk.
REQ-031 Reset mid-RUN or mid-PAUSED SHALL discard the count in progress.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until start or load.

Verification
REQ-033 Reset, then start, then 1 tick -> tens=5, ones=9 (borrow), running=1.
REQ-034 load 0/2, start, then 2 ticks -> 01, then 00; expired high exactly 1 cycle; zero=1; running=0; a third tick leaves 00.
REQ-035 RUN at 3/7: pause and tick in the same cycle -> 37 held in PAUSED; 5 ticks while paused -> 37; pause=0 then tick -> 36.
REQ-036 load tens=12, ones=15 -> tens=9, ones=9 in IDLE; start, then tick -> 98.
REQ-037 load 0/0, then start -> DONE on the next edge with a single expired pulse; load 1/0 from DONE -> IDLE showing 10 with no expired pulse.
REQ-038 Async reset asserted between clk edges mid-RUN at 4/2 -> outputs show 60 and running=0 before the next clk edge.
